// File: rtl/multilane_serializer_if.sv
// Bus between the transaction generator and the multilane serializer:
// link state, valid/ready word input and the per-lane serial outputs.
interface multilane_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2
);
    logic [1:0]                  trans_state;
    logic                        s_valid;
    logic                        s_ready;
    logic [LANES*DATA_WIDTH-1:0] s_data;
    logic [LANES-1:0]            serial_out;
    logic                        word_start;
    logic                        underrun;

    modport master (
        output trans_state, s_valid, s_data,
        input  s_ready, serial_out, word_start, underrun
    );

    modport slave (
        input  trans_state, s_valid, s_data,
        output s_ready, serial_out, word_start, underrun
    );
endinterface

// File: rtl/multilane_serializer.sv
// Serializes LANES parallel words onto LANES serial lines in lockstep, with a
// one-word holding buffer so back-to-back words leave without gaps.
module multilane_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    multilane_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        TS_DISCONNECTED = 2'd0,
        TS_IDLE         = 2'd1,
        TS_START        = 2'd2,
        TS_RESERVED     = 2'd3
    } transState_e;

    transState_e transState;
    logic        linkUp;
    logic        accept;

    logic [LANES*DATA_WIDTH-1:0]       holdData_q, holdData_d;
    logic                              holdFull_q, holdFull_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]                  bitCnt_q, bitCnt_d;
    logic [LANES-1:0]                  serialOut_q, serialOut_d;
    logic                              wordStart_q, wordStart_d;
    logic                              underrun_q, underrun_d;
    logic                              sReady_q, sReady_d;

    assign transState = transState_e'(bus.trans_state);
    assign linkUp     = (transState == TS_IDLE) || (transState == TS_START);
    assign accept     = bus.s_valid && sReady_q && linkUp;

    // The shift registers hold only the bits still to be sent; the bit on the
    // line always lives in serialOut_q, so bitCnt_q==0 marks a word boundary.
    always_comb begin
        holdData_d  = holdData_q;
        holdFull_d  = holdFull_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        serialOut_d = serialOut_q;
        wordStart_d = 1'b0;
        underrun_d  = 1'b0;

        if (accept) begin
            holdData_d = bus.s_data;
            holdFull_d = 1'b1;
        end

        case (transState)
            TS_IDLE: begin
                serialOut_d = '1;
                bitCnt_d    = '0;
            end
            TS_START: begin
                if (bitCnt_q == '0) begin
                    if (holdFull_q) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (MSB_FIRST) begin
                                serialOut_d[l] = holdData_q[l*DATA_WIDTH + DATA_WIDTH - 1];
                                shift_d[l]     = {holdData_q[l*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
                            end else begin
                                serialOut_d[l] = holdData_q[l*DATA_WIDTH];
                                shift_d[l]     = {1'b0, holdData_q[l*DATA_WIDTH+1 +: DATA_WIDTH-1]};
                            end
                        end
                        bitCnt_d    = LAST_CNT;
                        wordStart_d = 1'b1;
                        holdFull_d  = accept;
                    end else begin
                        serialOut_d = '1;
                        underrun_d  = 1'b1;
                    end
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        if (MSB_FIRST) begin
                            serialOut_d[l] = shift_q[l][DATA_WIDTH-1];
                            shift_d[l]     = {shift_q[l][DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            serialOut_d[l] = shift_q[l][0];
                            shift_d[l]     = {1'b0, shift_q[l][DATA_WIDTH-1:1]};
                        end
                    end
                    bitCnt_d = bitCnt_q - CNT_W'(1);
                end
            end
            default: begin
                serialOut_d = '0;
                holdFull_d  = 1'b0;
                bitCnt_d    = '0;
                shift_d     = '0;
            end
        endcase

        sReady_d = linkUp && !holdFull_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdData_q  <= '0;
            holdFull_q  <= 1'b0;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            serialOut_q <= '0;
            wordStart_q <= 1'b0;
            underrun_q  <= 1'b0;
            sReady_q    <= 1'b1;
        end else begin
            holdData_q  <= holdData_d;
            holdFull_q  <= holdFull_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            serialOut_q <= serialOut_d;
            wordStart_q <= wordStart_d;
            underrun_q  <= underrun_d;
            sReady_q    <= sReady_d;
        end
    end

    assign bus.serial_out = serialOut_q;
    assign bus.word_start = wordStart_q;
    assign bus.underrun   = underrun_q;
    assign bus.s_ready    = sReady_q;
endmodule

// File: tb/tb_multilane_serializer.sv
// Bench for multilane_serializer: an LSB-first and an MSB-first instance, with
// expected per-lane bit sequences queued by the stimulus and checked by monitors.
module tb_multilane_serializer;
    typedef struct {
        logic [15:0] seq;
        int          nbits;
    } expEntry_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   underrunCountA = 0;
    bit   capturing [2];
    expEntry_t expQ0 [$];
    expEntry_t expQ1 [$];

    multilane_serializer_if #(.DATA_WIDTH(8), .LANES(2)) busL ();
    multilane_serializer_if #(.DATA_WIDTH(8), .LANES(2)) busM ();

    multilane_serializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) dutL (
        .clk(clk), .rst(rst), .bus(busL)
    );
    multilane_serializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dutM (
        .clk(clk), .rst(rst), .bus(busM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic [1:0] state,
                                 input logic valid, input logic [15:0] data);
        if (which == 0) begin
            busL.trans_state = state;
            busL.s_valid     = valid;
            busL.s_data      = data;
        end else begin
            busM.trans_state = state;
            busM.s_valid     = valid;
            busM.s_data      = data;
        end
    endtask

    // Offers one word until it is accepted, then queues its expected bit
    // sequence (seq[j] is the bit on the line j cycles after word_start).
    task automatic pushWord(input int which, input logic [15:0] data, input int nbits);
        expEntry_t e;
        bit        done = 1'b0;
        logic      rdy;
        logic [1:0] st;
        st = (which == 0) ? busL.trans_state : busM.trans_state;
        e.seq   = (which == 1) ? {rev8(data[15:8]), rev8(data[7:0])} : data;
        e.nbits = nbits;
        applyStimulus(which, st, 1'b1, data);
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = (which == 0) ? busL.s_ready : busM.s_ready;
            tick();
            if (rdy) done = 1'b1;
        end
        applyStimulus(which, st, 1'b0, data);
        checkOutput("acceptTimeout", 32'(done), 32'd1);
        if (done) begin
            if (which == 0) expQ0.push_back(e);
            else            expQ1.push_back(e);
        end
    endtask

    task automatic waitDrain(input int which);
        bit drained = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            tick();
            drained = !capturing[which] &&
                      ((which == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0));
        end
        checkOutput("drainTimeout", 32'(drained), 32'd1);
    endtask

    task automatic monitorLoop(input int which);
        expEntry_t  e;
        int         j = 0;
        logic       ws, ur;
        logic [1:0] so;
        e.seq   = '0;
        e.nbits = 0;
        forever begin
            @(negedge clk);
            ws = (which == 0) ? busL.word_start : busM.word_start;
            ur = (which == 0) ? busL.underrun   : busM.underrun;
            so = (which == 0) ? busL.serial_out : busM.serial_out;
            if (rst) begin
                capturing[which] = 1'b0;
                continue;
            end
            if (which == 0 && ur) underrunCountA++;
            if (!capturing[which] && ws) begin
                if ((which == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWord lane-group %0d: got word_start 1, expected 0 (queue empty)", which);
                end else begin
                    if (which == 0) e = expQ0.pop_front();
                    else            e = expQ1.pop_front();
                    capturing[which] = 1'b1;
                    j = 0;
                end
            end
            if (capturing[which]) begin
                if (j > 0) checkOutput("wordStartMid", 32'(ws), 32'd0);
                checkOutput("serialBits", 32'(so), 32'({e.seq[8+j], e.seq[j]}));
                checkOutput("underrunInWord", 32'(ur), 32'd0);
                j++;
                if (j == e.nbits) capturing[which] = 1'b0;
            end
        end
    endtask

    initial monitorLoop(0);
    initial monitorLoop(1);

    initial begin
        int snap;
        rst = 1'b1;
        applyStimulus(0, 2'd1, 1'b0, 16'h0000);
        applyStimulus(1, 2'd0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;

        // Reset values, then link-state driven line levels.
        checkOutput("rstSerial", 32'(busL.serial_out), 32'd0);
        checkOutput("rstReady", 32'(busL.s_ready), 32'd1);
        checkOutput("rstWordStart", 32'(busL.word_start), 32'd0);
        checkOutput("rstUnderrun", 32'(busL.underrun), 32'd0);
        checkOutput("rstReadyM", 32'(busM.s_ready), 32'd1);
        rst = 1'b0;
        tick();
        checkOutput("idleSerial", 32'(busL.serial_out), 32'h3);
        checkOutput("idleReady", 32'(busL.s_ready), 32'd1);
        checkOutput("discSerialM", 32'(busM.serial_out), 32'd0);
        checkOutput("discReadyM", 32'(busM.s_ready), 32'd0);
        applyStimulus(0, 2'd0, 1'b0, 16'h0000);
        tick();
        checkOutput("discSerial", 32'(busL.serial_out), 32'd0);
        checkOutput("discReady", 32'(busL.s_ready), 32'd0);
        applyStimulus(0, 2'd1, 1'b0, 16'h0000);
        tick();
        checkOutput("idleSerial2", 32'(busL.serial_out), 32'h3);
        checkOutput("idleReady2", 32'(busL.s_ready), 32'd1);

        // START with nothing buffered underruns at every boundary.
        applyStimulus(0, 2'd2, 1'b0, 16'h0000);
        tick();
        checkOutput("emptyUnderrun", 32'(busL.underrun), 32'd1);
        checkOutput("emptySerial", 32'(busL.serial_out), 32'h3);

        pushWord(0, 16'hA53C, 8);
        waitDrain(0);

        for (int i = 0; i < 3; i++) begin
            checkOutput("retryUnderrun", 32'(busL.underrun), 32'd1);
            checkOutput("retrySerial", 32'(busL.serial_out), 32'h3);
            checkOutput("retryWordStart", 32'(busL.word_start), 32'd0);
            tick();
        end
        pushWord(0, 16'h0FF0, 8);
        waitDrain(0);

        // Three words offered back to back must leave with no gap.
        pushWord(0, 16'h1122, 8);
        pushWord(0, 16'h3344, 8);
        #6;
        snap = underrunCountA;
        pushWord(0, 16'h5566, 8);
        waitDrain(0);
        checkOutput("backToBackUnderruns", 32'(underrunCountA - snap), 32'd0);

        // MSB-first instance.
        applyStimulus(1, 2'd2, 1'b0, 16'h0000);
        tick();
        pushWord(1, 16'h5A80, 8);
        waitDrain(1);
        applyStimulus(1, 2'd0, 1'b0, 16'h0000);

        // Abort after three bits via IDLE, resume with the buffered word,
        // then hit reset in the middle of it.
        pushWord(0, 16'hC3E7, 3);
        pushWord(0, 16'h6B2D, 4);
        tick();
        applyStimulus(0, 2'd1, 1'b0, 16'h0000);
        tick();
        checkOutput("abortIdleSerial", 32'(busL.serial_out), 32'h3);
        checkOutput("abortIdleReady", 32'(busL.s_ready), 32'd0);
        checkOutput("abortIdleWordStart", 32'(busL.word_start), 32'd0);
        tick();
        checkOutput("abortIdleSerial2", 32'(busL.serial_out), 32'h3);
        applyStimulus(0, 2'd2, 1'b0, 16'h0000);
        repeat (4) tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstSerial", 32'(busL.serial_out), 32'd0);
        checkOutput("asyncRstReady", 32'(busL.s_ready), 32'd1);
        checkOutput("asyncRstWordStart", 32'(busL.word_start), 32'd0);
        applyStimulus(0, 2'd0, 1'b0, 16'h0000);
        tick();
        checkOutput("heldRstSerial", 32'(busL.serial_out), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        checkOutput("queueEmptyL", 32'(expQ0.size()), 32'd0);
        checkOutput("queueEmptyM", 32'(expQ1.size()), 32'd0);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
